// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, 2*DW-bit dividend by DW-bit divisor,
// one quotient bit per clock behind a start/busy/done handshake.
// Optional feature macro: SEQ_DIVIDER_DIV_ZERO_CHECK_EN (zero-divisor fast path).
// Timing: operands captured on the accepting edge; results and the done pulse are
// registered on the edge that leaves the DONE state, so done appears 2*DW+2 cycles
// after accept (2 on the zero-divisor fast path) and the next start is accepted in
// the same cycle that done is visible.
module seq_divider #(
    parameter int unsigned DW = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [2*DW-1:0]   dividend_i,
    input  logic [DW-1:0]     divisor_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [2*DW-1:0]   quotient_o,
    output logic [DW-1:0]     remainder_o,
    output logic              div_by_zero_o
);

    localparam int unsigned QW = 2 * DW;
    localparam int unsigned CW = $clog2(QW + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [QW-1:0]   dvd_q, dvd_d;
    logic [DW-1:0]   dvs_q, dvs_d;
    logic [QW-1:0]   q_q, q_d;
    logic [DW:0]     r_q, r_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [QW-1:0]   quot_q, quot_d;
    logic [DW-1:0]   rem_q, rem_d;
`ifdef SEQ_DIVIDER_DIV_ZERO_CHECK_EN
    logic            zero_q, zero_d;
    logic            dbz_q, dbz_d;
`endif

    // Trial value for one restoring step: shifted partial remainder and its difference.
    logic [DW:0]     t_c;
    logic [DW:0]     diff_c;
    logic            ge_c;

    assign t_c    = {r_q[DW-1:0], q_q[QW-1]};
    assign ge_c   = (t_c >= {1'b0, dvs_q});
    assign diff_c = t_c - {1'b0, dvs_q};

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        q_d     = q_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
`ifdef SEQ_DIVIDER_DIV_ZERO_CHECK_EN
        zero_d  = zero_q;
        dbz_d   = dbz_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    dvd_d   = dividend_i;
                    dvs_d   = divisor_i;
                end
            end
            S_LOAD: begin
                q_d    = dvd_q;
                r_d    = '0;
                cnt_d  = CW'(QW);
                quot_d = '0;
                rem_d  = '0;
                state_d = S_RUN;
`ifdef SEQ_DIVIDER_DIV_ZERO_CHECK_EN
                dbz_d  = 1'b0;
                zero_d = (dvs_q == '0);
                if (dvs_q == '0) begin
                    state_d = S_DONE;
                end
`endif
            end
            S_RUN: begin
                q_d   = {q_q[QW-2:0], ge_c};
                r_d   = ge_c ? diff_c : t_c;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                quot_d  = q_q;
                rem_d   = r_q[DW-1:0];
`ifdef SEQ_DIVIDER_DIV_ZERO_CHECK_EN
                if (zero_q) begin
                    quot_d = '1;
                    rem_d  = dvd_q[DW-1:0];
                    dbz_d  = 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_DONE);
    end

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
`ifdef SEQ_DIVIDER_DIV_ZERO_CHECK_EN
            zero_q  <= 1'b0;
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            q_q     <= q_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
`ifdef SEQ_DIVIDER_DIV_ZERO_CHECK_EN
            zero_q  <= zero_d;
            dbz_q   <= dbz_d;
`endif
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign quotient_o  = quot_q;
    assign remainder_o = rem_q;
`ifdef SEQ_DIVIDER_DIV_ZERO_CHECK_EN
    assign div_by_zero_o = dbz_q;
`else
    assign div_by_zero_o = 1'b0;
`endif

endmodule
